// File: rtl/alu_op_sequencer.sv
// Issue/capture stage for the WIDTH-bit ripple ALU array.
// Latches one op, waits for the ripple to settle, then holds result and flags.
module alu_op_sequencer #(
  parameter int WIDTH         = 128,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [2:0]       in_opsel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_opsel,
  output logic             alu_cin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_cout,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_ovf,
  output logic             out_err
);

  localparam int CW = $clog2(SETTLE_CYCLES) + 1;
  localparam logic [CW-1:0] CNT_INIT = CW'(SETTLE_CYCLES - 1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETTLE = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          accept;
  logic          illegal;
  logic          cin_dec;
  logic          eb_msb;
  logic          ovf_cap;

  // Ready is forced low while reset is held.
  assign in_ready  = rst_n && (state == S_IDLE);
  assign out_valid = (state == S_DONE);
  assign accept    = in_valid && in_ready;
  assign illegal   = (in_opsel == 3'd7);

  always_comb begin
    cin_dec = 1'b0;
    unique case (1'b1)
      (in_opsel == 3'd3): cin_dec = 1'b1;
      (in_opsel == 3'd4): cin_dec = 1'b1;
      (in_opsel == 3'd6): cin_dec = 1'b1;
      default:            cin_dec = 1'b0;
    endcase
  end

  // Sign bit of the B operand as the slices see it.
  always_comb begin
    eb_msb = 1'b0;
    unique case (1'b1)
      (alu_opsel == 3'd0): eb_msb = alu_b[WIDTH-1];
      (alu_opsel == 3'd6): eb_msb = alu_b[WIDTH-1];
      (alu_opsel == 3'd1): eb_msb = ~alu_b[WIDTH-1];
      (alu_opsel == 3'd3): eb_msb = ~alu_b[WIDTH-1];
      (alu_opsel == 3'd5): eb_msb = 1'b1;
      default:             eb_msb = 1'b0;
    endcase
  end

  assign ovf_cap = (alu_opsel != 3'd2)
                && (alu_a[WIDTH-1] == eb_msb)
                && (alu_result[WIDTH-1] != alu_a[WIDTH-1]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      alu_opsel  <= '0;
      alu_cin    <= 1'b0;
      out_result <= '0;
      out_carry  <= 1'b0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
      out_ovf    <= 1'b0;
      out_err    <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            cnt <= CNT_INIT;
            if (illegal) begin
              state      <= S_DONE;
              out_err    <= 1'b1;
              out_result <= '0;
              out_carry  <= 1'b0;
              out_zero   <= 1'b1;
              out_neg    <= 1'b0;
              out_ovf    <= 1'b0;
            end else begin
              state     <= S_SETTLE;
              alu_a     <= in_a;
              alu_b     <= in_b;
              alu_opsel <= in_opsel;
              alu_cin   <= cin_dec;
              out_err   <= 1'b0;
            end
          end
        end
        S_SETTLE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            state      <= S_DONE;
            out_result <= alu_result;
            out_carry  <= alu_cout;
            out_zero   <= (alu_result == '0);
            out_neg    <= alu_result[WIDTH-1];
            out_ovf    <= ovf_cap;
          end
        end
        S_DONE: begin
          if (out_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: models the ripple array and checks
// results, flags, latency and handshakes against an arithmetic model.
module tb_alu_op_sequencer;

  localparam int W = 128;
  localparam int SC = 4;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic [2:0]   in_opsel;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_opsel;
  logic         alu_cin;
  logic [W-1:0] alu_result;
  logic         alu_cout;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_result;
  logic         out_carry;
  logic         out_zero;
  logic         out_neg;
  logic         out_ovf;
  logic         out_err;

  int checks = 0;
  int errors = 0;

  logic [W-1:0] last_a;
  logic [W-1:0] last_b;
  logic [2:0]   last_op;
  logic         last_cin;

  always #5 clk = ~clk;

  alu_op_sequencer #(.WIDTH(W), .SETTLE_CYCLES(SC)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_opsel(in_opsel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_opsel(alu_opsel),
    .alu_cin(alu_cin), .alu_result(alu_result), .alu_cout(alu_cout),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry),
    .out_zero(out_zero), .out_neg(out_neg),
    .out_ovf(out_ovf), .out_err(out_err)
  );

  // Ripple array stand-in: every slice sees opsel and forms its own B.
  logic [W-1:0] arr_eb;
  logic [W:0]   arr_s;
  always_comb begin
    arr_eb = '0;
    case (alu_opsel)
      3'd0, 3'd6: arr_eb = alu_b;
      3'd1, 3'd3: arr_eb = ~alu_b;
      3'd5:       arr_eb = '1;
      default:    arr_eb = '0;
    endcase
    arr_s = {1'b0, alu_a} + {1'b0, arr_eb} + {{W{1'b0}}, alu_cin};
  end
  assign alu_result = arr_s[W-1:0];
  assign alu_cout   = arr_s[W];

  task automatic chk(input string tag, input logic [W-1:0] o,
                     input logic [W-1:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Reference: plain unsigned/signed arithmetic on the operands.
  task automatic model(input logic [2:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, output logic [W-1:0] r,
                       output logic c, output logic v);
    logic [W:0]         s;
    logic signed [W+2:0] sa, sb, sv, hi, lo;
    sa = $signed({{3{a[W-1]}}, a});
    sb = $signed({{3{b[W-1]}}, b});
    hi = $signed({4'b0, {(W-1){1'b1}}});
    lo = -hi - 1;
    sv = '0;
    r = '0;
    c = 1'b0;
    case (op)
      3'd0: begin
        s = {1'b0, a} + {1'b0, b};
        r = s[W-1:0]; c = s[W]; sv = sa + sb;
      end
      3'd1: begin r = a + ~b; c = (a > b); sv = sa - sb - 1; end
      3'd2: begin r = a; sv = sa; end
      3'd3: begin r = a - b; c = (a >= b); sv = sa - sb; end
      3'd4: begin r = a + 1'b1; c = &a; sv = sa + 1; end
      3'd5: begin r = a - 1'b1; c = (a != '0); sv = sa - 1; end
      3'd6: begin
        s = {1'b0, a} + {1'b0, b} + 1'b1;
        r = s[W-1:0]; c = s[W]; sv = sa + sb + 1;
      end
      default: begin r = '0; sv = '0; end
    endcase
    v = (sv > hi) || (sv < lo);
  endtask

  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input int hold);
    logic [W-1:0] er;
    logic ec, ev, ecin;
    int n;
    model(op, a, b, er, ec, ev);
    ecin = (op == 3'd3) || (op == 3'd4) || (op == 3'd6);
    @(negedge clk);
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_opsel = op;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {127'b0, in_ready}, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_a = $urandom();
    if (op != 3'd7) begin
      last_a = a;
      last_b = b;
      last_op = op;
      last_cin = ecin;
    end
    chk("alu_a", alu_a, last_a);
    chk("alu_b", alu_b, last_b);
    chk("alu_opsel", {125'b0, alu_opsel}, {125'b0, last_op});
    chk("alu_cin", {127'b0, alu_cin}, {127'b0, last_cin});
    n = 0;
    while (!out_valid && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("latency", n, (op == 3'd7) ? 0 : SC);
    chk("result", out_result, er);
    chk("carry", {127'b0, out_carry}, {127'b0, ec});
    chk("zero", {127'b0, out_zero}, {127'b0, er == '0});
    chk("neg", {127'b0, out_neg}, {127'b0, er[W-1]});
    chk("ovf", {127'b0, out_ovf}, {127'b0, ev});
    chk("err", {127'b0, out_err}, {127'b0, op == 3'd7});
    chk("busy_ready", {127'b0, in_ready}, 0);
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_a = ~a;
      in_b = a;
      in_opsel = 3'd1;
      @(posedge clk);
      #1;
      chk("hold_valid", {127'b0, out_valid}, 1);
      chk("hold_result", out_result, er);
      chk("hold_ready", {127'b0, in_ready}, 0);
      chk("hold_alu_a", alu_a, last_a);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    chk("drain_valid", {127'b0, out_valid}, 0);
    chk("drain_ready", {127'b0, in_ready}, 1);
    chk("kept_result", out_result, er);
  endtask

  function automatic logic [W-1:0] rnd();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [W-1:0] maxpos;
  logic [2:0]   rop;

  initial begin
    rst_n = 1'b0;
    in_valid = 1'b0;
    in_a = '0;
    in_b = '0;
    in_opsel = '0;
    out_ready = 1'b0;
    last_a = '0;
    last_b = '0;
    last_op = '0;
    last_cin = 1'b0;
    maxpos = {1'b0, {(W-1){1'b1}}};
    #12;
    chk("rst_ready", {127'b0, in_ready}, 0);
    chk("rst_valid", {127'b0, out_valid}, 0);
    chk("rst_result", out_result, 0);
    chk("rst_alu_a", alu_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("post_rst_ready", {127'b0, in_ready}, 1);

    run_op(3'd0, 128'd5, 128'd7, 0);
    run_op(3'd3, 128'd3, 128'd3, 0);
    run_op(3'd3, 128'd0, 128'd1, 0);
    run_op(3'd4, maxpos, 128'd0, 0);
    run_op(3'd5, 128'd0, 128'd9, 0);
    run_op(3'd7, rnd(), rnd(), 0);
    run_op(3'd6, '1, 128'd0, 10);
    run_op(3'd2, ~maxpos, rnd(), 0);

    // Reset while the ripple is settling.
    @(negedge clk);
    in_valid = 1'b1;
    in_a = 128'd11;
    in_b = 128'd22;
    in_opsel = 3'd0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    last_a = '0;
    last_b = '0;
    last_op = '0;
    last_cin = 1'b0;
    chk("midrst_valid", {127'b0, out_valid}, 0);
    chk("midrst_ready", {127'b0, in_ready}, 0);
    chk("midrst_alu_b", alu_b, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("midrst_release", {127'b0, in_ready}, 1);
    run_op(3'd7, 128'd1, 128'd2, 0);
    run_op(3'd0, 128'd100, 128'd23, 0);

    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      run_op(rop, (i % 5 == 0) ? maxpos : rnd(), rnd(), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
